// File: rtl/uriscv_muldiv_issue.sv
// Initiator-side issue controller for the M-extension multiply/divide unit.
// Holds one op at a time, returns its result to the register file and exports its rd.
module uriscv_muldiv_issue #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 7
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        op_valid_i,
   output logic        op_accept_o,
   input  logic [2:0]  op_func_i,
   input  logic [4:0]  op_rd_i,
   input  logic [31:0] op_ra_i,
   input  logic [31:0] op_rb_i,
   input  logic        flush_i,

   output logic        md_valid_o,
   output logic        md_inst_mul_o,
   output logic        md_inst_mulh_o,
   output logic        md_inst_mulhsu_o,
   output logic        md_inst_mulhu_o,
   output logic        md_inst_div_o,
   output logic        md_inst_divu_o,
   output logic        md_inst_rem_o,
   output logic        md_inst_remu_o,
   output logic [31:0] md_operand_ra_o,
   output logic [31:0] md_operand_rb_o,
   input  logic        md_stall_i,
   input  logic        md_ready_i,
   input  logic [31:0] md_result_i,

   output logic        wb_valid_o,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_value_o,
   input  logic        wb_accept_i,

   output logic        busy_o,
   output logic [4:0]  busy_rd_o,
   output logic        error_o
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StWb} state_e;

   state_e           state_q, state_d;
   logic [2:0]       func_q, func_d;
   logic [4:0]       rd_q, rd_d;
   logic [31:0]      ra_q, ra_d;
   logic [31:0]      rb_q, rb_d;
   logic [31:0]      result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             discard_q, discard_d;
   logic             take_op;
   logic             timeout;
   logic [7:0]       md_inst;

   assign take_op = op_valid_i & op_accept_o;
   // Counter is cleared on the accept edge, so it reads TIMEOUT_CYCLES-1 on the last WAIT cycle.
   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         func_q    <= 3'd0;
         rd_q      <= 5'd0;
         ra_q      <= 32'd0;
         rb_q      <= 32'd0;
         result_q  <= 32'd0;
         cnt_q     <= '0;
         discard_q <= 1'b0;
      end else begin
         func_q    <= func_d;
         rd_q      <= rd_d;
         ra_q      <= ra_d;
         rb_q      <= rb_d;
         result_q  <= result_d;
         cnt_q     <= cnt_d;
         discard_q <= discard_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (take_op) state_d = StIssue;
         end
         StIssue: begin
            if (!md_stall_i) begin
               state_d = StWait;
            end else if (flush_i) begin
               state_d = StIdle;
            end
         end
         StWait: begin
            if (md_ready_i) begin
               state_d = (discard_q || flush_i || rd_q == 5'd0) ? StIdle : StWb;
            end else if (timeout) begin
               state_d = StIdle;
            end
         end
         StWb: begin
            if (wb_accept_i) begin
               state_d = take_op ? StIssue : StIdle;
            end else if (flush_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Op, result, watchdog and discard bookkeeping
   always_comb begin
      func_d    = func_q;
      rd_d      = rd_q;
      ra_d      = ra_q;
      rb_d      = rb_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      discard_d = discard_q;
      if (take_op) begin
         func_d    = op_func_i;
         rd_d      = op_rd_i;
         ra_d      = op_ra_i;
         rb_d      = op_rb_i;
         discard_d = 1'b0;
      end
      if (state_q == StIssue && !md_stall_i) begin
         cnt_d     = '0;
         discard_d = flush_i;
      end
      if (state_q == StWait) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (flush_i) discard_d = 1'b1;
         if (md_ready_i) result_d = md_result_i;
      end
   end

   // Output logic
   always_comb begin
      op_accept_o = 1'b0;
      md_valid_o  = 1'b0;
      md_inst     = 8'd0;
      wb_valid_o  = 1'b0;
      wb_rd_o     = 5'd0;
      wb_value_o  = 32'd0;
      error_o     = 1'b0;
      unique case (state_q)
         StIdle: begin
            op_accept_o = !flush_i && !rst_i;
         end
         StIssue: begin
            md_valid_o = 1'b1;
            unique case (func_q)
               3'd0: md_inst = 8'b0000_0001;
               3'd1: md_inst = 8'b0000_0010;
               3'd2: md_inst = 8'b0000_0100;
               3'd3: md_inst = 8'b0000_1000;
               3'd4: md_inst = 8'b0001_0000;
               3'd5: md_inst = 8'b0010_0000;
               3'd6: md_inst = 8'b0100_0000;
               3'd7: md_inst = 8'b1000_0000;
               default: md_inst = 8'd0;
            endcase
         end
         StWait: begin
            error_o = timeout && !md_ready_i;
         end
         StWb: begin
            wb_valid_o  = 1'b1;
            wb_rd_o     = rd_q;
            wb_value_o  = result_q;
            op_accept_o = wb_accept_i && !flush_i && !rst_i;
         end
         default: ;
      endcase
      busy_o    = (state_q != StIdle) && !discard_q && (rd_q != 5'd0);
      busy_rd_o = busy_o ? rd_q : 5'd0;
   end

   assign md_inst_mul_o    = md_inst[0];
   assign md_inst_mulh_o   = md_inst[1];
   assign md_inst_mulhsu_o = md_inst[2];
   assign md_inst_mulhu_o  = md_inst[3];
   assign md_inst_div_o    = md_inst[4];
   assign md_inst_divu_o   = md_inst[5];
   assign md_inst_rem_o    = md_inst[6];
   assign md_inst_remu_o   = md_inst[7];
   assign md_operand_ra_o  = ra_q;
   assign md_operand_rb_o  = rb_q;

endmodule

// File: tb/tb_uriscv_muldiv_issue.sv
// Self-checking bench for uriscv_muldiv_issue: behavioural mul/div unit stub plus
// an arithmetic reference for every M-extension op.
module tb_uriscv_muldiv_issue;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        op_valid_i = 1'b0;
   logic        op_accept_o;
   logic [2:0]  op_func_i = 3'd0;
   logic [4:0]  op_rd_i = 5'd0;
   logic [31:0] op_ra_i = 32'd0;
   logic [31:0] op_rb_i = 32'd0;
   logic        flush_i = 1'b0;
   logic        md_valid_o;
   logic        md_inst_mul_o, md_inst_mulh_o, md_inst_mulhsu_o, md_inst_mulhu_o;
   logic        md_inst_div_o, md_inst_divu_o, md_inst_rem_o, md_inst_remu_o;
   logic [31:0] md_operand_ra_o, md_operand_rb_o;
   logic        md_stall_i = 1'b0;
   logic        md_ready_i = 1'b0;
   logic [31:0] md_result_i = 32'd0;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_value_o;
   logic        wb_accept_i = 1'b0;
   logic        busy_o;
   logic [4:0]  busy_rd_o;
   logic        error_o;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   bit          pend = 1'b0;
   bit          unit_dead = 1'b0;
   int          ready_at = 0;
   logic [31:0] pend_val = 32'd0;

   always #5 clk = ~clk;

   uriscv_muldiv_issue dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .op_valid_i       (op_valid_i),
      .op_accept_o      (op_accept_o),
      .op_func_i        (op_func_i),
      .op_rd_i          (op_rd_i),
      .op_ra_i          (op_ra_i),
      .op_rb_i          (op_rb_i),
      .flush_i          (flush_i),
      .md_valid_o       (md_valid_o),
      .md_inst_mul_o    (md_inst_mul_o),
      .md_inst_mulh_o   (md_inst_mulh_o),
      .md_inst_mulhsu_o (md_inst_mulhsu_o),
      .md_inst_mulhu_o  (md_inst_mulhu_o),
      .md_inst_div_o    (md_inst_div_o),
      .md_inst_divu_o   (md_inst_divu_o),
      .md_inst_rem_o    (md_inst_rem_o),
      .md_inst_remu_o   (md_inst_remu_o),
      .md_operand_ra_o  (md_operand_ra_o),
      .md_operand_rb_o  (md_operand_rb_o),
      .md_stall_i       (md_stall_i),
      .md_ready_i       (md_ready_i),
      .md_result_i      (md_result_i),
      .wb_valid_o       (wb_valid_o),
      .wb_rd_o          (wb_rd_o),
      .wb_value_o       (wb_value_o),
      .wb_accept_i      (wb_accept_i),
      .busy_o           (busy_o),
      .busy_rd_o        (busy_rd_o),
      .error_o          (error_o)
   );

   function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      longint          sa, sb, zb, p;
      longint unsigned ua, ub, pu;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      zb = longint'(ub);
      case (f)
         3'd0: return a * b;
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * zb; return p[63:32]; end
         3'd3: begin pu = ua * ub; return pu[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            pu = ua / ub;
            return pu[31:0];
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb;
            return p[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            pu = ua % ub;
            return pu[31:0];
         end
      endcase
   endfunction

   function automatic logic [7:0] inst_vec();
      return {md_inst_remu_o, md_inst_rem_o, md_inst_divu_o, md_inst_div_o,
              md_inst_mulhu_o, md_inst_mulhsu_o, md_inst_mulh_o, md_inst_mul_o};
   endfunction

   // Advance one clock; the unit stub accepts when valid && !stall, answers after 2 or 34 cycles.
   task automatic tick();
      logic [7:0] oh;
      logic [2:0] f;
      oh = inst_vec();
      if (rst_i) begin
         pend = 1'b0;
      end else if (md_valid_o === 1'b1 && !md_stall_i && !unit_dead) begin
         f = 3'd0;
         for (int i = 0; i < 8; i++) if (oh[i]) f = 3'(i);
         pend     = 1'b1;
         ready_at = cyc + (f[2] ? 34 : 2);
         pend_val = ($countones(oh) == 1) ? ref_md(f, md_operand_ra_o, md_operand_rb_o)
                                          : 32'hBAD0_BAD0;
      end
      @(posedge clk);
      #1;
      cyc++;
      md_ready_i  = pend && (cyc == ready_at);
      md_result_i = md_ready_i ? pend_val : $urandom();
      if (md_ready_i) pend = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         op_valid_i  = 1'b0;
         wb_accept_i = 1'b0;
         flush_i     = 1'b0;
         md_stall_i  = 1'b0;
      end
      #1;
   endtask

   // Issue one op from IDLE (or a WB accept cycle) and follow it to its writeback cycle.
   task automatic do_op(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int stall_n, input int wb_wait,
                        input bit wb_flush);
      logic [31:0] exp;
      logic [7:0]  exp_oh;
      int          c_acc, lat, t;
      bit          busy_exp;
      exp      = ref_md(f, a, b);
      exp_oh   = 8'd1 << f;
      lat      = f[2] ? 34 : 2;
      busy_exp = (rd != 5'd0);
      c_acc    = 0;
      op_valid_i = 1'b1; op_func_i = f; op_rd_i = rd; op_ra_i = a; op_rb_i = b;
      #1;
      checks++;
      if (op_accept_o !== 1'b1) begin
         failures++; $display("FAIL op_accept got=%b exp=1", op_accept_o);
      end
      tick();
      op_valid_i  = 1'b0;
      wb_accept_i = 1'b0;
      op_ra_i = $urandom(); op_rb_i = $urandom();
      op_func_i = 3'($urandom()); op_rd_i = 5'($urandom());
      md_stall_i = (stall_n > 0);
      for (int i = 0; i <= stall_n; i++) begin
         if (i == stall_n) md_stall_i = 1'b0;
         #1;
         checks++;
         if (md_valid_o !== 1'b1 || inst_vec() !== exp_oh) begin
            failures++;
            $display("FAIL issue_sel valid=%b inst=%b exp_inst=%b", md_valid_o, inst_vec(), exp_oh);
         end
         checks++;
         if (md_operand_ra_o !== a || md_operand_rb_o !== b) begin
            failures++;
            $display("FAIL issue_operands got=%h/%h exp=%h/%h", md_operand_ra_o,
                     md_operand_rb_o, a, b);
         end
         checks++;
         if (busy_o !== busy_exp || busy_rd_o !== (busy_exp ? rd : 5'd0)) begin
            failures++;
            $display("FAIL busy_issue got=%b/%0d exp=%b/%0d", busy_o, busy_rd_o, busy_exp, rd);
         end
         if (i == stall_n) c_acc = cyc;
         tick();
      end
      t = 0;
      while (t <= 60) begin
         #1;
         if (wb_valid_o === 1'b1 || op_accept_o === 1'b1) break;
         checks++;
         if (md_valid_o !== 1'b0 || busy_o !== busy_exp) begin
            failures++;
            $display("FAIL wait_state valid=%b busy=%b exp_busy=%b", md_valid_o, busy_o, busy_exp);
         end
         tick();
         t++;
      end
      checks++;
      if (cyc !== c_acc + lat + 1) begin
         failures++;
         $display("FAIL result_latency got_cycle=%0d exp_cycle=%0d", cyc, c_acc + lat + 1);
         return;
      end
      if (rd == 5'd0) begin
         checks++;
         if (wb_valid_o !== 1'b0 || op_accept_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rd0_no_wb wb=%b accept=%b busy=%b exp=0/1/0", wb_valid_o,
                     op_accept_o, busy_o);
         end
         return;
      end
      for (int i = 0; i <= wb_wait; i++) begin
         if (i == wb_wait) begin
            if (wb_flush) flush_i = 1'b1;
            else wb_accept_i = 1'b1;
         end
         #1;
         checks++;
         if (wb_valid_o !== 1'b1 || wb_rd_o !== rd || wb_value_o !== exp) begin
            failures++;
            $display("FAIL wb_data valid=%b rd=%0d val=%h exp rd=%0d val=%h", wb_valid_o,
                     wb_rd_o, wb_value_o, rd, exp);
         end
         checks++;
         if (op_accept_o !== (i == wb_wait && !wb_flush) || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL wb_ctrl accept=%b busy=%b exp_accept=%b exp_busy=1", op_accept_o,
                     busy_o, (i == wb_wait && !wb_flush));
         end
         if (i < wb_wait) tick();
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      idle(2);
      checks++;
      if ({op_accept_o, md_valid_o, inst_vec(), wb_valid_o, wb_rd_o, wb_value_o, busy_o,
           busy_rd_o, error_o, md_operand_ra_o, md_operand_rb_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs accept=%b valid=%b wb=%b busy=%b err=%b exp all 0",
                  op_accept_o, md_valid_o, wb_valid_o, busy_o, error_o);
      end
      rst_i = 1'b0;
      #1;
      checks++;
      if (op_accept_o !== 1'b1) begin
         failures++; $display("FAIL reset_release_accept got=%b exp=1", op_accept_o);
      end
   endtask

   task automatic test_directed_ops();
      do_op(3'd0, 5'd5, 32'd7, 32'd6, 0, 0, 1'b0);
      idle(1);
      do_op(3'd4, 5'd9, 32'hFFFF_FFEC, 32'd3, 0, 0, 1'b0);
      idle(1);
      do_op(3'd6, 5'd9, 32'hFFFF_FFEC, 32'd3, 0, 0, 1'b0);
      idle(1);
   endtask

   task automatic test_back_to_back();
      do_op(3'd3, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 5, 1'b0);
      do_op(3'd2, 5'd12, $urandom(), $urandom(), 0, 0, 1'b0);
      do_op(3'd4, 5'd2, 32'd1000, 32'd7, 0, 0, 1'b0);
      do_op(3'd0, 5'd3, 32'h1234_5678, 32'h9ABC_DEF0, 4, 0, 1'b0);
      idle(1);
   endtask

   task automatic test_rd0();
      do_op(3'd4, 5'd0, 32'd50, 32'd5, 0, 0, 1'b0);
      idle(1);
   endtask

   task automatic test_flush();
      int c_acc;
      // Flush in IDLE blocks acceptance
      op_valid_i = 1'b1; op_func_i = 3'd0; op_rd_i = 5'd8; flush_i = 1'b1;
      #1;
      checks++;
      if (op_accept_o !== 1'b0) begin
         failures++; $display("FAIL flush_idle_accept got=%b exp=0", op_accept_o);
      end
      idle(1);
      checks++;
      if (md_valid_o !== 1'b0) begin
         failures++; $display("FAIL flush_idle_no_issue got=%b exp=0", md_valid_o);
      end
      // Flush during WAIT: no writeback, stays occupied until the unit answers
      op_valid_i = 1'b1; op_func_i = 3'd4; op_rd_i = 5'd3; op_ra_i = 32'd100; op_rb_i = 32'd7;
      #1;
      tick();
      op_valid_i = 1'b0;
      #1;
      c_acc = cyc;
      tick();
      for (int i = 0; i < 10; i++) tick();
      flush_i = 1'b1;
      #1;
      tick();
      flush_i = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || busy_rd_o !== 5'd0) begin
         failures++; $display("FAIL flush_wait_busy got=%b/%0d exp=0/0", busy_o, busy_rd_o);
      end
      while (cyc < c_acc + 35) begin
         checks++;
         if (op_accept_o !== 1'b0 || wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_wait_hold accept=%b wb=%b busy=%b exp 0/0/0", op_accept_o,
                     wb_valid_o, busy_o);
         end
         tick();
         #1;
      end
      checks++;
      if (op_accept_o !== 1'b1 || wb_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_wait_release accept=%b wb=%b exp 1/0", op_accept_o, wb_valid_o);
      end
      // Flush in ISSUE while stalled: nothing issued
      op_valid_i = 1'b1; op_func_i = 3'd1; op_rd_i = 5'd6;
      #1;
      tick();
      op_valid_i = 1'b0; md_stall_i = 1'b1;
      #1;
      tick();
      flush_i = 1'b1;
      #1;
      checks++;
      if (md_valid_o !== 1'b1 || md_inst_mulh_o !== 1'b1) begin
         failures++; $display("FAIL flush_issue_hold valid=%b mulh=%b exp 1/1", md_valid_o,
                              md_inst_mulh_o);
      end
      idle(1);
      checks++;
      if (md_valid_o !== 1'b0 || op_accept_o !== 1'b1 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_issue_drop valid=%b accept=%b busy=%b exp 0/1/0", md_valid_o,
                  op_accept_o, busy_o);
      end
      // Flush in WB drops the writeback
      do_op(3'd1, 5'd4, 32'hF000_0000, 32'd16, 0, 2, 1'b1);
      idle(1);
      checks++;
      if (wb_valid_o !== 1'b0 || op_accept_o !== 1'b1) begin
         failures++; $display("FAIL flush_wb_drop wb=%b accept=%b exp 0/1", wb_valid_o,
                              op_accept_o);
      end
   endtask

   task automatic test_timeout();
      int c_acc, n_err, err_cyc;
      n_err = 0; err_cyc = -1;
      unit_dead = 1'b1;
      op_valid_i = 1'b1; op_func_i = 3'd5; op_rd_i = 5'd7; op_ra_i = 32'd9; op_rb_i = 32'd2;
      #1;
      tick();
      op_valid_i = 1'b0;
      #1;
      c_acc = cyc;
      tick();
      while (cyc <= c_acc + 64) begin
         if (error_o === 1'b1) begin n_err++; err_cyc = cyc; end
         tick();
      end
      #1;
      checks++;
      if (n_err != 1 || err_cyc != c_acc + 64) begin
         failures++;
         $display("FAIL timeout_pulse count=%0d at=%0d exp count=1 at=%0d", n_err, err_cyc,
                  c_acc + 64);
      end
      checks++;
      if (error_o !== 1'b0 || op_accept_o !== 1'b1 || busy_o !== 1'b0) begin
         failures++; $display("FAIL timeout_idle err=%b accept=%b busy=%b exp 0/1/0", error_o,
                              op_accept_o, busy_o);
      end
      md_ready_i = 1'b1; md_result_i = 32'h5555_AAAA;
      #1;
      tick();
      #1;
      checks++;
      if (wb_valid_o !== 1'b0 || op_accept_o !== 1'b1 || md_valid_o !== 1'b0) begin
         failures++; $display("FAIL late_ready_ignored wb=%b accept=%b valid=%b exp 0/1/0",
                              wb_valid_o, op_accept_o, md_valid_o);
      end
      unit_dead = 1'b0;
   endtask

   task automatic test_reset_mid();
      op_valid_i = 1'b1; op_func_i = 3'd6; op_rd_i = 5'd6; op_ra_i = 32'd77; op_rb_i = 32'd5;
      #1;
      tick();
      op_valid_i = 1'b0;
      #1;
      tick();
      tick();
      rst_i = 1'b1;
      #1;
      tick();
      rst_i = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || op_accept_o !== 1'b1 || md_valid_o !== 1'b0 ||
          wb_valid_o !== 1'b0) begin
         failures++; $display("FAIL reset_mid busy=%b accept=%b valid=%b wb=%b exp 0/1/0/0",
                              busy_o, op_accept_o, md_valid_o, wb_valid_o);
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'd1;
         default: return $urandom();
      endcase
   endfunction

   task automatic test_random();
      logic [4:0] rd;
      for (int n = 0; n < 30; n++) begin
         rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         do_op(3'($urandom_range(0, 7)), rd, pick_operand(), pick_operand(),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
         if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
      end
      idle(1);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout cycles=%0d exp finish earlier", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_directed_ops();
      test_back_to_back();
      test_rd0();
      test_flush();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
